// File: rtl/port_alloc_pipe.sv
// Port allocation result pipeline: decodes per-slot allocation vectors into
// crossbar select controls, buffers them in a 2-entry FIFO, and keeps
// deflection / multicast statistics plus a sticky grant-conflict flag.
module port_alloc_pipe #(
  parameter int unsigned NP = 4,
  parameter int unsigned SW = 2,
  parameter int unsigned CW = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NP*NP-1:0] in_alloc,
  input  logic [NP*NP-1:0] in_unalloc,
  input  logic [NP-1:0]    in_mc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NP*SW-1:0] out_sel,
  output logic [NP-1:0]    out_sel_vld,
  output logic [NP-1:0]    out_deflect,
  input  logic             clr_cnt,
  output logic [CW-1:0]    deflect_cnt,
  output logic [CW-1:0]    mc_copy_cnt,
  output logic             err_conflict
);

  localparam int unsigned EW = NP * SW + 2 * NP;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} stateT;

  stateT         stateQ, stateD;
  logic [EW-1:0] headQ, headD, tailQ, tailD, newEntry;

  logic [NP*SW-1:0] newSel;
  logic [NP-1:0]    portSeen;
  logic [NP-1:0]    newDeflect;
  logic             newConflict;
  logic [CW-1:0]    deflectInc, mcInc;
  logic [CW:0]      deflectSum, mcSum;
  logic [CW-1:0]    deflectCntQ, mcCntQ;
  logic             errQ;
  logic             accept, pop;

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  // Decode the offered allocation set; portSeen doubles as the select-valid vector.
  always_comb begin
    newSel      = '0;
    portSeen    = '0;
    newDeflect  = '0;
    newConflict = 1'b0;
    deflectInc  = '0;
    mcInc       = '0;
    // Walk slots from highest to lowest so the lowest granted slot wins.
    for (int j = 0; j < int'(NP); j++) begin
      for (int i = int'(NP) - 1; i >= 0; i--) begin
        if (in_alloc[i*NP+j]) newSel[j*SW +: SW] = SW'(i);
      end
    end
    for (int i = 0; i < int'(NP); i++) begin
      for (int j = 0; j < int'(NP); j++) begin
        if (in_alloc[i*NP+j]) begin
          if (portSeen[j]) newConflict = 1'b1;
          portSeen[j] = 1'b1;
          if (in_mc[i]) mcInc = mcInc + CW'(1);
        end
      end
      newDeflect[i] = |in_unalloc[i*NP +: NP];
      if (newDeflect[i]) deflectInc = deflectInc + CW'(1);
    end
    newEntry = {newDeflect, portSeen, newSel};
  end

  // FIFO next-state: head always holds the oldest entry.
  always_comb begin
    stateD = stateQ;
    headD  = headQ;
    tailD  = tailQ;
    case (stateQ)
      StEmpty: begin
        if (accept) begin
          stateD = StOne;
          headD  = newEntry;
        end
      end
      StOne: begin
        if (accept && pop) begin
          headD = newEntry;
        end else if (accept) begin
          stateD = StTwo;
          tailD  = newEntry;
        end else if (pop) begin
          stateD = StEmpty;
        end
      end
      StTwo: begin
        if (pop) begin
          stateD = StOne;
          headD  = tailQ;
        end
      end
      default: stateD = StEmpty;
    endcase
  end

  // FIFO state and storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ <= StEmpty;
      headQ  <= '0;
      tailQ  <= '0;
    end else begin
      stateQ <= stateD;
      headQ  <= headD;
      tailQ  <= tailD;
    end
  end

  // Widened sums expose the carry used for saturation.
  always_comb begin
    deflectSum = {1'b0, deflectCntQ} + {1'b0, deflectInc};
    mcSum      = {1'b0, mcCntQ} + {1'b0, mcInc};
  end

  // Statistics counters; clear beats a same-cycle increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deflectCntQ <= '0;
      mcCntQ      <= '0;
    end else if (clr_cnt) begin
      deflectCntQ <= '0;
      mcCntQ      <= '0;
    end else if (accept) begin
      deflectCntQ <= deflectSum[CW] ? '1 : deflectSum[CW-1:0];
      mcCntQ      <= mcSum[CW] ? '1 : mcSum[CW-1:0];
    end
  end

  // Sticky conflict flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      errQ <= 1'b0;
    end else if (accept && newConflict) begin
      errQ <= 1'b1;
    end
  end

  assign in_ready                              = (stateQ != StTwo);
  assign out_valid                             = (stateQ != StEmpty);
  assign {out_deflect, out_sel_vld, out_sel}   = headQ;
  assign deflect_cnt                           = deflectCntQ;
  assign mc_copy_cnt                           = mcCntQ;
  assign err_conflict                          = errQ;

endmodule

// File: tb/tb_port_alloc_pipe.sv
// Directed bench for port_alloc_pipe with hand-computed expectations.
module tb_port_alloc_pipe;

  localparam int unsigned NP = 4;
  localparam int unsigned SW = 2;
  localparam int unsigned CW = 16;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [NP*NP-1:0] in_alloc;
  logic [NP*NP-1:0] in_unalloc;
  logic [NP-1:0]    in_mc;
  logic             out_valid;
  logic             out_ready;
  logic [NP*SW-1:0] out_sel;
  logic [NP-1:0]    out_sel_vld;
  logic [NP-1:0]    out_deflect;
  logic             clr_cnt;
  logic [CW-1:0]    deflect_cnt;
  logic [CW-1:0]    mc_copy_cnt;
  logic             err_conflict;

  int nChecks = 0;
  int nFails  = 0;

  port_alloc_pipe #(
    .NP(NP),
    .SW(SW),
    .CW(CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_alloc    (in_alloc),
    .in_unalloc  (in_unalloc),
    .in_mc       (in_mc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sel     (out_sel),
    .out_sel_vld (out_sel_vld),
    .out_deflect (out_deflect),
    .clr_cnt     (clr_cnt),
    .deflect_cnt (deflect_cnt),
    .mc_copy_cnt (mc_copy_cnt),
    .err_conflict(err_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_alloc   = '0;
    in_unalloc = '0;
    in_mc      = '0;
    out_ready  = 1'b0;
    clr_cnt    = 1'b0;
    #3;
    checkVal("rst_in_ready", 64'(in_ready), 64'h1);
    checkVal("rst_out_valid", 64'(out_valid), 64'h0);
    checkVal("rst_sel_vld", 64'(out_sel_vld), 64'h0);
    checkVal("rst_deflect_cnt", 64'(deflect_cnt), 64'h0);
    checkVal("rst_err", 64'(err_conflict), 64'h0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    checkVal("idle_out_valid", 64'(out_valid), 64'h0);

    // Single accept: slot1 -> port2.
    in_valid  = 1'b1;
    in_alloc  = 16'h0040;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checkVal("single_out_valid", 64'(out_valid), 64'h1);
    checkVal("single_sel_vld", 64'(out_sel_vld), 64'h4);
    checkVal("single_sel", 64'(out_sel), 64'h10);
    checkVal("single_deflect", 64'(out_deflect), 64'h0);
    tick();
    checkVal("single_one_cycle", 64'(out_valid), 64'h0);

    // Back-to-back accepts with the consumer stalled.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_alloc  = 16'h0001;
    tick();
    checkVal("b2b_ready_after1", 64'(in_ready), 64'h1);
    in_alloc = 16'h0800;
    tick();
    checkVal("b2b_ready_after2", 64'(in_ready), 64'h0);
    checkVal("b2b_head_hold", 64'(out_sel_vld), 64'h1);
    in_alloc = 16'h2000;
    tick();
    in_valid = 1'b0;
    checkVal("b2b_third_ignored", 64'(in_ready), 64'h0);
    checkVal("b2b_head_a_vld", 64'(out_sel_vld), 64'h1);
    checkVal("b2b_head_a_sel", 64'(out_sel), 64'h0);
    out_ready = 1'b1;
    tick();
    checkVal("b2b_pop1_valid", 64'(out_valid), 64'h1);
    checkVal("b2b_head_b_vld", 64'(out_sel_vld), 64'h8);
    checkVal("b2b_head_b_sel", 64'(out_sel), 64'h80);
    checkVal("b2b_pop1_ready", 64'(in_ready), 64'h1);
    tick();
    checkVal("b2b_drained", 64'(out_valid), 64'h0);
    checkVal("b2b_no_deflect_cnt", 64'(deflect_cnt), 64'h0);

    // Multicast copies and deflection counting.
    in_valid   = 1'b1;
    in_alloc   = 16'h000B;
    in_unalloc = 16'h0100;
    in_mc      = 4'b0001;
    tick();
    checkVal("mc_cnt_first", 64'(mc_copy_cnt), 64'h3);
    checkVal("mc_deflect_cnt", 64'(deflect_cnt), 64'h1);
    checkVal("mc_out_deflect", 64'(out_deflect), 64'h4);
    checkVal("mc_sel_vld", 64'(out_sel_vld), 64'hB);
    in_alloc   = 16'h004B;
    in_unalloc = '0;
    tick();
    in_valid = 1'b0;
    in_mc    = '0;
    checkVal("mc_cnt_second", 64'(mc_copy_cnt), 64'h6);
    checkVal("mc_deflect_hold", 64'(deflect_cnt), 64'h1);
    checkVal("mc_sel_all", 64'(out_sel_vld), 64'hF);
    checkVal("mc_sel_port2", 64'(out_sel), 64'h10);
    checkVal("mc_no_conflict", 64'(err_conflict), 64'h0);
    tick();

    // Two slots granted the same port.
    in_valid = 1'b1;
    in_alloc = 16'h2002;
    tick();
    checkVal("conf_sel_vld", 64'(out_sel_vld), 64'h2);
    checkVal("conf_lowest_wins", 64'(out_sel), 64'h0);
    checkVal("conf_err_set", 64'(err_conflict), 64'h1);
    in_alloc = 16'h0001;
    tick();
    in_valid = 1'b0;
    checkVal("conf_err_sticky", 64'(err_conflict), 64'h1);
    checkVal("conf_next_vld", 64'(out_sel_vld), 64'h1);
    tick();

    // Clear without accept, then drive deflect_cnt into saturation.
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    checkVal("clr_deflect", 64'(deflect_cnt), 64'h0);
    checkVal("clr_mc", 64'(mc_copy_cnt), 64'h0);
    checkVal("clr_err_kept", 64'(err_conflict), 64'h1);
    in_valid   = 1'b1;
    in_alloc   = '0;
    in_unalloc = 16'h1111;
    for (int k = 0; k < 16383; k++) tick();
    checkVal("sat_near", 64'(deflect_cnt), 64'hFFFC);
    checkVal("sat_out_deflect", 64'(out_deflect), 64'hF);
    tick();
    checkVal("sat_reach", 64'(deflect_cnt), 64'hFFFF);
    tick();
    checkVal("sat_hold", 64'(deflect_cnt), 64'hFFFF);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    checkVal("clr_beats_inc", 64'(deflect_cnt), 64'h0);

    // Fill to two entries, then reset between clock edges.
    out_ready  = 1'b0;
    in_unalloc = 16'h0011;
    tick();
    in_valid = 1'b0;
    checkVal("fill_two_ready", 64'(in_ready), 64'h0);
    checkVal("fill_deflect_cnt", 64'(deflect_cnt), 64'h2);
    #2;
    reset = 1'b1;
    #1;
    checkVal("arst_out_valid", 64'(out_valid), 64'h0);
    checkVal("arst_in_ready", 64'(in_ready), 64'h1);
    checkVal("arst_deflect_cnt", 64'(deflect_cnt), 64'h0);
    checkVal("arst_mc_cnt", 64'(mc_copy_cnt), 64'h0);
    checkVal("arst_err", 64'(err_conflict), 64'h0);
    checkVal("arst_outs", 64'({out_sel, out_sel_vld, out_deflect}), 64'h0);
    tick();
    reset = 1'b0;
    tick();
    checkVal("post_rst_valid", 64'(out_valid), 64'h0);
    checkVal("post_rst_err", 64'(err_conflict), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/port_alloc_pipe.md
PORT_ALLOC_PIPE -- requirements
Module: port_alloc_pipe

Interface
REQ-001 SHALL have parameter NP, default 4, meaning the number of network ports (NUM_PORT-1) and allocator slots.
REQ-002 SHALL have parameter SW, default 2, meaning the slot index width (clog2 NP).
REQ-003 SHALL have parameter CW, default 16, meaning the statistics counter width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, meaning an allocation result set is offered.
REQ-007 SHALL have port in_ready, output, 1, meaning the block accepts this cycle.
REQ-008 SHALL have port in_alloc, input, NP*NP, allocatedPortVector of slot i at bits [i*NP +: NP].
REQ-009 SHALL have port in_unalloc, input, NP*NP, unallocPortVector of slot i at bits [i*NP +: NP].
REQ-010 SHALL have port in_mc, input, NP, meaning slot i carries a multicast flit.
REQ-011 SHALL have port out_valid, output, 1, meaning the head entry is presented.
REQ-012 SHALL have port out_ready, input, 1, meaning the crossbar consumes the head entry.
REQ-013 SHALL have port out_sel, output, NP*SW, the source slot for output port j at [j*SW +: SW].
REQ-014 SHALL have port out_sel_vld, output, NP, meaning output port j is driven.
REQ-015 SHALL have port out_deflect, output, NP, meaning slot i has at least one unallocated productive port.
REQ-016 SHALL have port clr_cnt, input, 1, synchronous counter clear.
REQ-017 SHALL have port deflect_cnt, output, CW, accumulated deflected-slot count.
REQ-018 SHALL have port mc_copy_cnt, output, CW, accumulated multicast copies granted.
REQ-019 SHALL have port err_conflict, output, 1, sticky flag for two slots granted the same port.

Function
REQ-020 SHALL accept an entry on the cycle where in_valid and in_ready are both high.
REQ-021 SHALL, for each accepted entry, compute out_sel_vld[j] as the OR over i of in_alloc[i][j].
REQ-022 SHALL set out_sel[j] to the lowest slot i with in_alloc[i][j]=1, and to 0 when none is set.
REQ-023 SHALL set out_deflect[i] as the OR-reduction of slot i's in_unalloc.
REQ-024 SHALL store the decoded result in a 2-entry FIFO, and out_* SHALL show the head entry.
REQ-025 SHALL use the FIFO state machine EMPTY, ONE and TWO, with in_ready = (state != TWO), registered from state.
REQ-026 SHALL move EMPTY->ONE on accept; ONE->TWO on accept without pop; ONE->EMPTY on pop without accept; TWO->ONE on pop; all other cases hold state.
REQ-027 SHALL present the entry with out_valid=1 on the cycle after an accept into EMPTY (latency 1).
REQ-028 SHALL, on a simultaneous accept and pop in ONE, stay in ONE and present the new entry next cycle.
REQ-029 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-030 SHALL ignore in_valid while in TWO, with no state or counter change.
REQ-031 SHALL, on each accept, add the popcount of out_deflect (NP bits) to deflect_cnt.
REQ-032 SHALL, on each accept, add to mc_copy_cnt the popcount of in_alloc[i] for every slot with in_mc[i]=1.
REQ-033 SHALL saturate both counters at 2^CW-1 with no wrap.
REQ-034 SHALL make clr_cnt win over a same-cycle increment: counters go to 0 and that accept's increments are discarded.
REQ-035 SHALL set err_conflict when an accepted entry has any port j granted to two or more slots.
REQ-036 SHALL clear err_conflict only by reset.
REQ-037 SHALL still use lowest-slot-wins selection (REQ-022) for a conflicting entry.

Reset
REQ-038 SHALL, while reset is high, asynchronously force the state to EMPTY and out_valid to 0.
REQ-039 SHALL, while reset is high, force in_ready=1 and out_sel, out_sel_vld, out_deflect to 0.
REQ-040 SHALL, while reset is high, force deflect_cnt, mc_copy_cnt and err_conflict to 0.
REQ-041 SHALL discard FIFO contents on a reset asserted mid-operation, with no output glitch to out_valid=1.

Verification
REQ-042 SHALL pass: single accept with slot1 alloc=0100, others 0, out_ready=1 -> next cycle out_valid=1, out_sel_vld=0100, out_sel[2]=1, one cycle only.
REQ-043 SHALL pass: three back-to-back accepts with out_ready=0 -> in_ready=0 after the second, third ignored, then two pops deliver entries 1 and 2 in order.
REQ-044 SHALL pass: slot0 mc=1 alloc=1011, slot2 unalloc=0001 -> mc_copy_cnt=3, deflect_cnt=1.
REQ-045 SHALL pass: slots 0 and 3 both alloc=0010 -> out_sel[1]=0 and err_conflict=1 until reset.
REQ-046 SHALL pass: deflect_cnt preloaded near 0xFFFF via repeated 4-deflect accepts -> holds 0xFFFF; clr_cnt with accept same cycle -> 0.
REQ-047 SHALL pass: reset asserted in TWO state -> out_valid=0, in_ready=1, counters 0 immediately, without waiting for a clock edge.
